// File: rtl/cr_xp10_decomp_im_arb_if.sv
// XP10 decompressor IM capture arbiter bundle.
// Requester handshake, RAM write port and bank handshake.
interface cr_xp10_decomp_im_arb_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 11
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [2*N_REQ-1:0]      im_avail;
  logic [2*N_REQ-1:0]      im_consumed;
  logic                    spurious_consume;

  modport master (
    output req_valid, req_data, im_consumed,
    input  req_ready, wr_en, wr_addr, wr_data,
    input  im_avail, spurious_consume
  );

  modport slave (
    input  req_valid, req_data, im_consumed,
    output req_ready, wr_en, wr_addr, wr_data,
    output im_avail, spurious_consume
  );
endinterface

// File: rtl/cr_xp10_decomp_im_arb.sv
// XP10 decompressor IM capture RAM write-port arbiter.
// Round-robin grant over requesters, each with ping-pong banks.
module cr_xp10_decomp_im_arb #(
  parameter int N_REQ      = 3,
  parameter int DATA_W     = 64,
  parameter int BANK_DEPTH = 256,
  localparam int OFS_W     = $clog2(BANK_DEPTH),
  localparam int ADDR_W    = 2 + 1 + OFS_W
) (
  input logic clk,
  input logic rst_n,
  cr_xp10_decomp_im_arb_if.slave bus
);
  localparam int NB = 2 * N_REQ;
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_AVAIL = 2'd2;
  localparam logic [1:0] LAST    = 2'(N_REQ - 1);

  logic [1:0]        st [NB];
  logic [OFS_W-1:0]  ofs [N_REQ];
  logic [N_REQ-1:0]  fill_bank;
  logic [1:0]        rr_ptr;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  ready;
  logic [NB-1:0]     avail_st;
  logic              gnt_vld;
  logic [1:0]        gnt;
  logic [2:0]        gbank;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [NB-1:0]     im_avail_q;
  logic              spur_q;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = bus.req_valid[i] &&
        (st[2*i + int'(fill_bank[i])] != S_AVAIL);
    avail_st = '0;
    for (int j = 0; j < NB; j++)
      avail_st[j] = (st[j] == S_AVAIL);
  end

  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt = '0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt = 2'(idx);
      end
    end
    ready = '0;
    if (gnt_vld)
      ready[gnt] = 1'b1;
    gbank = {gnt, fill_bank[gnt]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NB; j++)
        st[j] <= S_EMPTY;
      for (int i = 0; i < N_REQ; i++)
        ofs[i] <= '0;
      fill_bank  <= '0;
      rr_ptr     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      im_avail_q <= '0;
      spur_q     <= 1'b0;
    end else begin
      wr_en_q <= gnt_vld;
      spur_q  <= |(bus.im_consumed & ~avail_st);
      // A bank being consumed never equals the bank being filled
      for (int j = 0; j < NB; j++) begin
        im_avail_q[j] <= avail_st[j] && !bus.im_consumed[j];
        if (bus.im_consumed[j] && avail_st[j])
          st[j] <= S_EMPTY;
      end
      if (gnt_vld) begin
        wr_addr_q <= {gnt, fill_bank[gnt], ofs[gnt]};
        wr_data_q <= bus.req_data[int'(gnt)*DATA_W +: DATA_W];
        ofs[gnt]  <= ofs[gnt] + 1'b1;
        rr_ptr    <= (gnt == LAST) ? 2'd0 : gnt + 2'd1;
        if (ofs[gnt] == '1) begin
          st[gbank]      <= S_AVAIL;
          fill_bank[gnt] <= ~fill_bank[gnt];
        end else begin
          st[gbank] <= S_FILL;
        end
      end
    end
  end

  assign bus.req_ready        = ready;
  assign bus.wr_en            = wr_en_q;
  assign bus.wr_addr          = wr_addr_q;
  assign bus.wr_data          = wr_data_q;
  assign bus.im_avail         = im_avail_q;
  assign bus.spurious_consume = spur_q;
endmodule
